// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and the matching transmitter.
// Holds the receiver state encodings and the clocks-per-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    // Integer division: any remainder shows up as a small baud error.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for an asynchronous input.
// RESET_VAL sets both flops so the output is defined out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; only q is consumed downstream.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, start + WORD_SIZE data bits (LSB first)
// + optional parity + one stop bit. Define UART_RX_PARITY_EN to add the parity bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line high, waiting for a falling edge on rx_s
// START    | half a bit in, confirm the start bit (high = glitch)
// DATA     | sample one data bit every bit period, LSB first
// PARITY   | sample the parity bit and latch a mismatch
// STOP     | sample the stop bit, report word or error(s)
// BREAK    | stop bit was low; wait for the line to go high again
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int WORD_SIZE  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 rx,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_out_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int B     = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int H     = B / 2;
    localparam int CNT_W = $clog2(B);
    localparam int BIT_W = $clog2(WORD_SIZE + 1);

    localparam logic [CNT_W-1:0] B_LAST   = CNT_W'(B - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);

    if (B < 4) begin : g_bad_baud
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    logic                 rx_s;
    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic [WORD_SIZE-1:0] data_d;
    logic                 valid_d, ferr_d;
    logic                 cnt_last;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (rx),
        .q       (rx_s)
    );

    assign cnt_last = (cnt_q == B_LAST);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_mis_q, par_mis_d, perr_d;
`else
    logic unused_par;
    assign unused_par = PARITY_ODD[0];
    assign parity_err = 1'b0;
`endif

    // Next state, counters, shift register and registered outcome pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_out;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_mis_d = par_mis_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                par_mis_d = 1'b0;
`endif
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[WORD_SIZE-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    par_mis_d = rx_s ^ (^shift_q) ^ PAR_ODD;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid-stop-bit so an immediate next start bit is caught.
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_mis_q;
`endif
                        state_d = ST_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_mis_q) begin
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            data_out       <= data_d;
            data_out_valid <= valid_d;
            frame_err      <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch latch and its outcome pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            par_mis_q  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_mis_q  <= par_mis_d;
            parity_err <= perr_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with B=16, H=8, WORD_SIZE=8.
// Expected outcomes are queued as frames are driven; a negedge monitor queues
// what the DUT reports and each test pops and compares the two.
module tb_uart_rx;

    localparam int B = 16;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_err;
    logic       parity_err;

    uart_rx #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (1),
        .WORD_SIZE  (8),
        .PARITY_ODD (0)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .rx             (rx),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_err      (frame_err),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    // flags = {valid, frame_err, parity_err}
    typedef struct {
        logic [2:0] flags;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (data_out_valid || frame_err || parity_err) begin
            ev_t o;
            o.flags = {data_out_valid, frame_err, parity_err};
            o.data  = data_out;
            o.cyc   = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(B);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit((^d) ^ par_flip);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic push_exp(input logic [2:0] flags, input logic [7:0] d);
        ev_t e;
        e.flags = flags;
        e.data  = d;
        e.cyc   = 0;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        rx = 1'b1;
        tick(3);
        checks++;
        if ({data_out, data_out_valid, frame_err, parity_err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b%b%b want 00/000",
                     data_out, data_out_valid, frame_err, parity_err);
        end
        n_reset = 1'b1;
        tick(5);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_quiet got %0d events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_single;
        int n0;
        ev_t o;
        push_exp(3'b100, 8'hA5);
        n0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(20);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (o.flags !== exp_q[0].flags || o.data !== exp_q[0].data) begin
                errors++;
                $display("FAIL single_event got %b/%h want %b/%h", o.flags, o.data,
                         exp_q[0].flags, exp_q[0].data);
            end
            // rx_s falls 2 edges after the pin; pulse on cycle H+9B+1 = 153 after that.
            checks++;
            if (o.cyc !== n0 + 2 + 153) begin
                errors++;
                $display("FAIL single_latency got %0d want %0d", o.cyc - n0, 2 + 153);
            end
        end
        checks++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold got %h want a5", data_out);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        ev_t e, o;
        push_exp(3'b100, 8'h00);
        push_exp(3'b100, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        tick(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.flags !== e.flags || o.data !== e.data) begin
                errors++;
                $display("FAIL b2b_event got %b/%h want %b/%h", o.flags, o.data, e.flags, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_glitch;
        ev_t e, o;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL glitch_quiet got %0d events want 0", obs_q.size());
        end
        obs_q.delete();
        push_exp(3'b100, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.flags !== e.flags || o.data !== e.data) begin
                errors++;
                $display("FAIL glitch_event got %b/%h want %b/%h", o.flags, o.data, e.flags, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        ev_t e, o;
        d = 8'h3B;
        checks++;
        if (data_out !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_pre got %h want 5a", data_out);
        end
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        tick(B / 2);
        n_reset = 1'b0;
        #1;
        checks++;
        if ({data_out, data_out_valid, frame_err, parity_err} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_outputs got %h/%b%b%b want 00/000",
                     data_out, data_out_valid, frame_err, parity_err);
        end
        rx = 1'b1;
        tick(4);
        n_reset = 1'b1;
        tick(40);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d events want 0", obs_q.size());
        end
        obs_q.delete();
        push_exp(3'b100, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        tick(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.flags !== e.flags || o.data !== e.data) begin
                errors++;
                $display("FAIL midrst_event got %b/%h want %b/%h", o.flags, o.data, e.flags, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_frame_err;
        ev_t e, o;
        n_reset = 1'b0;
        rx = 1'b1;
        tick(2);
        n_reset = 1'b1;
        tick(5);
        push_exp(3'b010, 8'h00);
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        tick(50);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL ferr_count got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.flags !== e.flags) begin
                errors++;
                $display("FAIL ferr_event got %b want %b", o.flags, e.flags);
            end
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL ferr_data_hold got %h want 00", data_out);
        end
        exp_q.delete();
        obs_q.delete();
        rx = 1'b1;
        tick(B);
        push_exp(3'b100, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL ferr_next_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.flags !== e.flags || o.data !== e.data) begin
                errors++;
                $display("FAIL ferr_next_event got %b/%h want %b/%h", o.flags, o.data, e.flags, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_parity;
        ev_t e, o;
        push_exp(3'b100, 8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        push_exp(3'b001, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        tick(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL parity_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.flags !== e.flags || o.data !== e.data) begin
                errors++;
                $display("FAIL parity_event got %b/%h want %b/%h", o.flags, o.data, e.flags, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        test_frame_err();
        if (PAR_EN) test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that turns the `rx` line into one parallel word per frame. It sits directly upstream of the message assembler. Its `data_out`/`data_out_valid` connect straight to the assembler's `data_in`/`data_in_valid`. Frame format is 8N1 by default: start bit, `WORD_SIZE` data bits LSB first, an optional parity bit, and one stop bit.

## Interface
Parameters:
- `CLK_FREQ`, 12000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division). Must be ≥ 4; elaboration fails otherwise.
- `WORD_SIZE`, 8: data bits per frame.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Used only when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `n_reset`  in  1  reset, asynchronous and active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `data_out`  out  `WORD_SIZE`  last received word. Holds its value until the next good frame.
- `data_out_valid`  out  1  one-cycle pulse when `data_out` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1, to produce `rx_s`.
- `B = CLKS_PER_BIT`, `H = B/2` (floor). The bit-period counter is `$clog2(B)` bits wide; the bit index counter is `$clog2(WORD_SIZE+1)` bits wide.
- Reset state: IDLE, counters 0. `data_out`=0, `data_out_valid`=0, `frame_err`=0, `parity_err`=0.
- IDLE
  - On `rx_s`==0, clear the counter and go to START.
- START
  - Wait H cycles, then sample `rx_s`.
  - If 0, go to DATA with the counter cleared.
  - If 1, the start was a glitch: return to IDLE with no output.
- DATA
  - Every B cycles, sample `rx_s` into a shift register, LSB first.
  - After `WORD_SIZE` samples, go to PARITY if compiled in, otherwise to STOP.
- PARITY
  - After B cycles, sample the parity bit and latch the mismatch flag.
  - Go to STOP.
- STOP
  - After B cycles, sample the stop bit.
  - Stop=1 and no parity mismatch: load `data_out`, pulse `data_out_valid`, go to IDLE.
  - Stop=0: pulse `frame_err` (and `parity_err` too if a mismatch was latched), go to BREAK. `data_out` is unchanged.
  - Stop=1 with parity mismatch: pulse `parity_err` only, go to IDLE. `data_out` is unchanged.
- BREAK
  - Wait for `rx_s`==1, then go to IDLE. A held-low line therefore never produces a spurious frame.
- Leaving STOP at mid-stop-bit is deliberate: a back-to-back start bit (zero idle time) is caught with half a bit of margin.
- `n_reset` asserted at any time forces the reset state immediately. A partial frame is discarded.

## Timing
- Cycle 0 is the first cycle `rx_s`==0 in IDLE; `rx_s` lags the `rx` pin by 2 cycles.
- Start sample at cycle H. Data bit k is sampled at cycle H + (k+1)·B, for k = 0..`WORD_SIZE`-1.
- Stop sample at cycle H + (`WORD_SIZE`+1)·B, or H + (`WORD_SIZE`+2)·B with parity.
- Outputs are registered: `data_out_valid`, `frame_err` and `parity_err` are high on the cycle after the stop sample, for exactly one cycle.
- `data_out` is valid on that same cycle.
- There is no backpressure; the consumer must accept every pulse.
- At most one outcome pulse occurs per frame: valid, or error(s), never both.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state present; the frame has one parity bit per `PARITY_ODD`.
  - `parity_err` is live.
- Not defined:
  - No PARITY state; DATA goes straight to STOP.
  - `parity_err` is a constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the state encodings (IDLE, START, DATA, PARITY, STOP, BREAK);
  - a constant function computing `CLKS_PER_BIT` from `CLK_FREQ`/`BAUD_RATE`, which the matching transmitter reuses.
- One sub-module: `sync_2ff`, a 1-bit two-flop synchronizer with asynchronous active-low reset and a reset-value parameter.

## Test plan
All directed tests use `CLK_FREQ`=16, `BAUD_RATE`=1 (B=16, H=8) and `WORD_SIZE`=8.
- Single frame 0xA5, stop=1 -> exactly one `data_out_valid` pulse with `data_out`=0xA5, at cycle 8+9·16+1 after `rx_s` falls.
- Back-to-back 0x00 then 0xFF with zero idle bits -> two valid pulses carrying 0x00 then 0xFF; no errors.
- `rx` low for 4 cycles then high -> no pulses on any output; next frame 0x5A is received correctly.
- Frame 0x55 with stop=0, then `rx` held low 50 cycles, then 0x3C -> one `frame_err` pulse and no valid during the low period; then valid with 0x3C. `data_out` stays 0x00 until then.
- `n_reset` low during data bit 3 -> all outputs 0 immediately. After release, frame 0x81 gives a valid pulse with 0x81.
- Parity tests, with `UART_RX_PARITY_EN` defined and `PARITY_ODD`=0:
  - 0x07 with parity bit 1 -> valid with 0x07.
  - 0x07 with parity bit 0 -> `parity_err` pulse, no valid.
